mem_stage: RTL and testbench

Memory-access pipeline stage plus MEM/WB pipeline register, sitting directly upstream of the write-back stage. Drives the data-memory request/response handshake for loads and stores, generates the byte write mask and lane-replicated store data, and stalls the pipeline until memory responds. Registers the raw read word, byte address, ALU result and control word that write-back needs to select and extend load data.

---
 rtl/mem_stage_pkg.sv | 41 ++++
 rtl/mem_store_align.sv | 31 +++
 rtl/mem_stage.sv | 134 +++++++++++++
 tb/tb_mem_stage.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: control word, store funct3 decode,
// memory-stage FSM states and byte-mask constants.
package mem_stage_pkg;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  typedef enum logic [3:0] {
    RF_ALU_OUT,
    RF_BR_EN,
    RF_U_IMM,
    RF_LW,
    RF_PC_PLUS4,
    RF_LB,
    RF_LBU,
    RF_LH,
    RF_LHU
  } regfilemux_sel_t;

  typedef struct packed {
    logic            load_regfile;
    regfilemux_sel_t regfilemux_sel;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      funct3;
  } rv32i_control_word;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;

endpackage

// File: rtl/mem_store_align.sv
// Store lane alignment: byte enables and lane-replicated write data from
// funct3 and the low address bits. Purely combinational.
module mem_store_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  output logic [3:0]  wmask,
  output logic [31:0] wdata
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch is inferred.
    wmask = 4'b0000;
    wdata = rs2;
    case (store_funct3_t'(funct3))
      SB: begin
        wmask = MASK_B << addr_lo;
        wdata = {4{rs2[7:0]}};
      end
      SH: begin
        wmask = MASK_H << {addr_lo[1], 1'b0};
        wdata = {2{rs2[15:0]}};
      end
      SW:      wmask = MASK_W;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage plus MEM/WB register. Optional misaligned-access trap
// is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int width = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_valid_i,
  input  rv32i_control_word MEM_ctrl_word_i,
  input  logic [width-1:0]  MEM_alu_out_i,
  input  logic [width-1:0]  MEM_rs2_i,
  input  logic [4:0]        MEM_rd_i,
  input  logic [width-1:0]  MEM_pc_out_i,
  input  logic [width-1:0]  MEM_u_imm_i,
  input  logic              MEM_br_en_i,
  input  logic              MEM_stall_i,
  output logic              MEM_stall_o,
  output logic [width-1:0]  dmem_address_o,
  output logic              dmem_read_o,
  output logic              dmem_write_o,
  output logic [3:0]        dmem_wmask_o,
  output logic [width-1:0]  dmem_wdata_o,
  input  logic [width-1:0]  dmem_rdata_i,
  input  logic              dmem_resp_i,
  output logic              WB_valid_o,
  output rv32i_control_word WB_ctrl_word_o,
  output logic [4:0]        WB_rd_o,
  output logic [width-1:0]  WB_alu_out_o,
  output logic [width-1:0]  WB_data_mem_rdata_o,
  output logic [width-1:0]  WB_data_mem_address_o,
  output logic [width-1:0]  WB_pc_out_o,
  output logic [width-1:0]  WB_u_imm_o,
  output logic              WB_br_en_o,
  output logic              MEM_misalign_o
);

  state_t            state, state_next;
  logic [width-1:0]  hold_rdata;
  logic              memop, misalign, active, done, wb_load;
  logic [3:0]        align_mask;
  logic [31:0]       align_wdata;
  rv32i_control_word wb_ctrl;

  // Gating with rst keeps strobes and stall low the instant reset asserts.
  assign memop = rst & MEM_valid_i &
                 (MEM_ctrl_word_i.mem_read | MEM_ctrl_word_i.mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = memop &
    (((MEM_ctrl_word_i.funct3[1:0] == 2'b01) & MEM_alu_out_i[0]) |
     ((MEM_ctrl_word_i.funct3[1:0] == 2'b10) & (MEM_alu_out_i[1:0] != 2'b00)));
  assign MEM_misalign_o = (state == IDLE) & misalign & ~MEM_stall_i;
`else
  assign misalign       = 1'b0;
  assign MEM_misalign_o = 1'b0;
`endif

  assign active      = ((state == IDLE) & memop & ~misalign) | ((state == WAIT) & memop);
  assign done        = active & dmem_resp_i;
  assign MEM_stall_o = active & ~dmem_resp_i;
  assign wb_load     = ~MEM_stall_i & ~MEM_stall_o;

  mem_store_align u_align (
    .funct3  (MEM_ctrl_word_i.funct3),
    .addr_lo (MEM_alu_out_i[1:0]),
    .rs2     (MEM_rs2_i),
    .wmask   (align_mask),
    .wdata   (align_wdata)
  );

  assign dmem_address_o = {MEM_alu_out_i[width-1:2], 2'b00};
  assign dmem_read_o    = active & MEM_ctrl_word_i.mem_read;
  assign dmem_write_o   = active & MEM_ctrl_word_i.mem_write;
  assign dmem_wmask_o   = dmem_write_o ? align_mask : 4'b0000;
  assign dmem_wdata_o   = align_wdata;

  always_comb begin
    state_next = state;
    case (state)
      IDLE, WAIT: begin
        if (done)        state_next = MEM_stall_i ? HOLD : IDLE;
        else if (active) state_next = WAIT;
        else             state_next = IDLE;
      end
      HOLD:    if (!MEM_stall_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      // NOTE: the hold buffer is a single word, not an array, so it shares the async reset.
      hold_rdata <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
      state <= state_next;
      if (done && MEM_stall_i) hold_rdata <= dmem_rdata_i;
    end
  end

  always_comb begin
    wb_ctrl              = MEM_ctrl_word_i;
    wb_ctrl.load_regfile = MEM_ctrl_word_i.load_regfile & MEM_valid_i & ~misalign;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WB_valid_o            <= 1'b0;
      WB_ctrl_word_o        <= '0;
      WB_rd_o               <= '0;
      WB_alu_out_o          <= '0;
      WB_data_mem_rdata_o   <= '0;
      WB_data_mem_address_o <= '0;
      WB_pc_out_o           <= '0;
      WB_u_imm_o            <= '0;
      WB_br_en_o            <= 1'b0;
    end else if (wb_load) begin
      WB_valid_o            <= MEM_valid_i;
      WB_ctrl_word_o        <= wb_ctrl;
      WB_rd_o               <= MEM_rd_i;
      WB_alu_out_o          <= MEM_alu_out_i;
      // A response parked during a global stall is replayed from the hold buffer.
      WB_data_mem_rdata_o   <= (state == HOLD) ? hold_rdata : dmem_rdata_i;
      WB_data_mem_address_o <= MEM_alu_out_i;
      WB_pc_out_o           <= MEM_pc_out_i;
      WB_u_imm_o            <= MEM_u_imm_i;
      WB_br_en_o            <= MEM_br_en_i;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table with a write-back
// scoreboard, plus hand-written hold, misalign and reset sequences.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              MEM_valid_i;
  rv32i_control_word MEM_ctrl_word_i;
  logic [31:0]       MEM_alu_out_i, MEM_rs2_i, MEM_pc_out_i, MEM_u_imm_i;
  logic [4:0]        MEM_rd_i;
  logic              MEM_br_en_i, MEM_stall_i, MEM_stall_o;
  logic [31:0]       dmem_address_o, dmem_wdata_o, dmem_rdata_i;
  logic              dmem_read_o, dmem_write_o, dmem_resp_i;
  logic [3:0]        dmem_wmask_o;
  logic              WB_valid_o, WB_br_en_o, MEM_misalign_o;
  rv32i_control_word WB_ctrl_word_o;
  logic [4:0]        WB_rd_o;
  logic [31:0]       WB_alu_out_o, WB_data_mem_rdata_o, WB_data_mem_address_o;
  logic [31:0]       WB_pc_out_o, WB_u_imm_o;

  mem_stage #(.width(32)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .MEM_valid_i           (MEM_valid_i),
    .MEM_ctrl_word_i       (MEM_ctrl_word_i),
    .MEM_alu_out_i         (MEM_alu_out_i),
    .MEM_rs2_i             (MEM_rs2_i),
    .MEM_rd_i              (MEM_rd_i),
    .MEM_pc_out_i          (MEM_pc_out_i),
    .MEM_u_imm_i           (MEM_u_imm_i),
    .MEM_br_en_i           (MEM_br_en_i),
    .MEM_stall_i           (MEM_stall_i),
    .MEM_stall_o           (MEM_stall_o),
    .dmem_address_o        (dmem_address_o),
    .dmem_read_o           (dmem_read_o),
    .dmem_write_o          (dmem_write_o),
    .dmem_wmask_o          (dmem_wmask_o),
    .dmem_wdata_o          (dmem_wdata_o),
    .dmem_rdata_i          (dmem_rdata_i),
    .dmem_resp_i           (dmem_resp_i),
    .WB_valid_o            (WB_valid_o),
    .WB_ctrl_word_o        (WB_ctrl_word_o),
    .WB_rd_o               (WB_rd_o),
    .WB_alu_out_o          (WB_alu_out_o),
    .WB_data_mem_rdata_o   (WB_data_mem_rdata_o),
    .WB_data_mem_address_o (WB_data_mem_address_o),
    .WB_pc_out_o           (WB_pc_out_o),
    .WB_u_imm_o            (WB_u_imm_o),
    .WB_br_en_o            (WB_br_en_o),
    .MEM_misalign_o        (MEM_misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, rd, wr, lr;
    logic [2:0]  f3;
    logic [31:0] addr, rs2, rdata;
    int          waits;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic        valid, lr, br_en;
    logic [4:0]  rd;
    logic [31:0] alu, rdata, pc, u_imm;
  } wb_exp_t;

  vec_t    vecs[10];
  wb_exp_t wb_q[$];
  int      n_checks = 0;
  int      n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic valid, rd, wr, lr, input logic [2:0] f3,
                       input logic [31:0] addr, rs2, input int idx);
    MEM_valid_i     = valid;
    MEM_ctrl_word_i = '{load_regfile: lr, regfilemux_sel: (rd ? RF_LW : RF_ALU_OUT),
                        mem_read: rd, mem_write: wr, funct3: f3};
    MEM_alu_out_i   = addr;
    MEM_rs2_i       = rs2;
    MEM_rd_i        = 5'(idx + 1);
    MEM_pc_out_i    = 32'h100 + 32'(idx * 4);
    MEM_u_imm_i     = 32'(idx) << 12;
    MEM_br_en_i     = idx[0];
  endtask

  task automatic push_exp(input logic valid, lr, input logic [31:0] alu, rdata, input int idx);
    wb_exp_t e;
    e.valid = valid;
    e.lr    = lr;
    e.rd    = 5'(idx + 1);
    e.alu   = alu;
    e.rdata = rdata;
    e.pc    = 32'h100 + 32'(idx * 4);
    e.u_imm = 32'(idx) << 12;
    e.br_en = idx[0];
    wb_q.push_back(e);
  endtask

  task automatic compare_wb(input string tag);
    wb_exp_t e;
    if (wb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_scoreboard: no expected entry queued", tag);
      return;
    end
    e = wb_q.pop_front();
    check1({tag, "_wb_valid"}, WB_valid_o, e.valid);
    check1({tag, "_wb_load_regfile"}, WB_ctrl_word_o.load_regfile, e.lr);
    check({tag, "_wb_rd"}, 32'(WB_rd_o), 32'(e.rd));
    check({tag, "_wb_alu"}, WB_alu_out_o, e.alu);
    check({tag, "_wb_rdata"}, WB_data_mem_rdata_o, e.rdata);
    check({tag, "_wb_addr"}, WB_data_mem_address_o, e.alu);
    check({tag, "_wb_pc"}, WB_pc_out_o, e.pc);
    check({tag, "_wb_u_imm"}, WB_u_imm_o, e.u_imm);
    check1({tag, "_wb_br_en"}, WB_br_en_o, e.br_en);
  endtask

  // Entered and left at posedge+1; the memory answers after v.waits cycles.
  task automatic apply_vec(input vec_t v, input int idx);
    logic  memop;
    int    stalls;
    string tag;
    tag    = $sformatf("v%0d", idx);
    memop  = v.valid & (v.rd | v.wr);
    stalls = 0;
    drive(v.valid, v.rd, v.wr, v.lr, v.f3, v.addr, v.rs2, idx);
    dmem_rdata_i = v.rdata;
    dmem_resp_i  = memop & (v.waits == 0);
    push_exp(v.valid, v.valid & v.lr, v.addr, v.rdata, idx);
    for (int c = 0; c <= v.waits; c++) begin
      @(negedge clk);
      if (MEM_stall_o) stalls++;
      check1($sformatf("%s_read_c%0d", tag, c), dmem_read_o, memop & v.rd);
      check1($sformatf("%s_write_c%0d", tag, c), dmem_write_o, memop & v.wr);
      if (c == 0) begin
        check({tag, "_wmask"}, 32'(dmem_wmask_o), 32'(v.exp_mask));
        check({tag, "_address"}, dmem_address_o, {v.addr[31:2], 2'b00});
        if (v.wr) check({tag, "_wdata"}, dmem_wdata_o, v.exp_wdata);
      end
      @(posedge clk);
      #1;
      dmem_resp_i = memop & (c + 1 == v.waits);
    end
    check({tag, "_stall_cycles"}, 32'(stalls), memop ? 32'(v.waits) : 32'd0);
    compare_wb(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of the test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int reqs;

    //          valid rd   wr   lr   f3      addr          rs2           rdata         w  mask     wdata
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0,         0, 4'b1000, 32'hA5A5_A5A5};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_1000, 32'h0000_0012, 32'h0,         1, 4'b0001, 32'h1212_1212};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 32'h0000_1002, 32'h0000_BEEF, 32'h0,         0, 4'b1100, 32'hBEEF_BEEF};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 32'h0000_1000, 32'h0000_1234, 32'h0,         0, 4'b0011, 32'h1234_1234};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_1004, 32'hCAFE_F00D, 32'h0,         2, 4'b1111, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_2000, 32'h0,         32'hDEAD_BEEF, 3, 4'b0000, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_0055, 32'h0000_0007, 32'h0,         0, 4'b0000, 32'h0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_2001, 32'h0,         32'h1122_3344, 1, 4'b0000, 32'h0};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_2008, 32'h0,         32'h0000_0099, 0, 4'b0000, 32'h0};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b101, 32'h0000_2006, 32'h0,         32'hCAFE_0000, 0, 4'b0000, 32'h0};

    rst          = 1'b0;
    MEM_stall_i  = 1'b0;
    dmem_resp_i  = 1'b0;
    dmem_rdata_i = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1;
    check1("rst_wb_valid", WB_valid_o, 1'b0);
    check("rst_wb_ctrl", 32'(WB_ctrl_word_o), 32'h0);
    check("rst_wb_alu", WB_alu_out_o, 32'h0);
    check("rst_wb_rdata", WB_data_mem_rdata_o, 32'h0);
    check("rst_wb_pc", WB_pc_out_o, 32'h0);
    check1("rst_read", dmem_read_o, 1'b0);
    check1("rst_write", dmem_write_o, 1'b0);
    check("rst_wmask", 32'(dmem_wmask_o), 32'h0);
    check1("rst_stall", MEM_stall_o, 1'b0);
    check1("rst_misalign", MEM_misalign_o, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) apply_vec(vecs[i], i);

    // lh completes while the global stall is high: parked in HOLD, replayed later.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0, 10);
    MEM_stall_i  = 1'b1;
    dmem_resp_i  = 1'b1;
    dmem_rdata_i = 32'hDEAD_BEEF;
    push_exp(1'b1, 1'b1, 32'h0000_2002, 32'hDEAD_BEEF, 10);
    reqs = 0;
    @(negedge clk);
    if (dmem_read_o) reqs++;
    check1("hold_stall_c0", MEM_stall_o, 1'b0);
    @(posedge clk);
    #1;
    dmem_resp_i  = 1'b0;
    dmem_rdata_i = 32'h0;
    @(negedge clk);
    if (dmem_read_o) reqs++;
    check1("hold_stall_c1", MEM_stall_o, 1'b0);
    check("hold_wb_frozen_c1", WB_alu_out_o, 32'h0000_2006);
    @(posedge clk);
    #1;
    MEM_stall_i = 1'b0;
    @(negedge clk);
    if (dmem_read_o) reqs++;
    check("hold_wb_frozen_c2", WB_alu_out_o, 32'h0000_2006);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 11);
    check("hold_request_count", 32'(reqs), 32'd1);
    compare_wb("hold");

    // sh to an odd address.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 32'h0000_3001, 32'h0000_1234, 12);
    dmem_resp_i = 1'b1;
    push_exp(1'b1, 1'b0, 32'h0000_3001, 32'h0, 12);
    @(negedge clk);
    check1("mis_stall", MEM_stall_o, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
    check1("mis_write", dmem_write_o, 1'b0);
    check1("mis_pulse", MEM_misalign_o, 1'b1);
`else
    check1("mis_write", dmem_write_o, 1'b1);
    check("mis_wmask", 32'(dmem_wmask_o), 32'h3);
    check("mis_wdata", dmem_wdata_o, 32'h1234_1234);
    check1("mis_pulse", MEM_misalign_o, 1'b0);
`endif
    @(posedge clk);
    #1;
    dmem_resp_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 13);
    compare_wb("mis");
    @(negedge clk);
    check1("mis_pulse_end", MEM_misalign_o, 1'b0);

    // Reset lands while a load waits on memory.
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_4000, 32'h0, 14);
    @(negedge clk);
    check1("rw_read_c0", dmem_read_o, 1'b1);
    check1("rw_stall_c0", MEM_stall_o, 1'b1);
    @(negedge clk);
    check1("rw_read_wait", dmem_read_o, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check1("rw_read_in_reset", dmem_read_o, 1'b0);
    check1("rw_write_in_reset", dmem_write_o, 1'b0);
    check1("rw_stall_in_reset", MEM_stall_o, 1'b0);
    check1("rw_wb_valid_in_reset", WB_valid_o, 1'b0);
    MEM_valid_i = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    dmem_resp_i  = 1'b1;
    dmem_rdata_i = 32'h0000_0077;
    #1;
    check1("rw_late_resp_read", dmem_read_o, 1'b0);
    check1("rw_late_resp_stall", MEM_stall_o, 1'b0);
    @(posedge clk);
    #1;
    dmem_resp_i = 1'b0;
    check1("rw_late_wb_valid", WB_valid_o, 1'b0);
    check1("rw_late_wb_load_regfile", WB_ctrl_word_o.load_regfile, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
